// File: rtl/input_debounce_ctrl_if.sv
// ---------------------------------------------------------------------------
// input_debounce_ctrl_if
//   Groups the switch/pending/interrupt signals exchanged between the core
//   side (master) and the debounce controller (slave).
//
//   i_sw_sync   : synchronized 32-bit switch word       (master -> slave)
//   i_clr_en    : pending-clear strobe                  (master -> slave)
//   i_clr_mask  : write-1-to-clear mask for pending     (master -> slave)
//   i_irq_mask  : per-bit interrupt enable              (master -> slave)
//   o_sw_stable : debounced switch word                 (slave -> master)
//   o_pending   : sticky changed-bit flags              (slave -> master)
//   o_change    : one-cycle commit pulse                (slave -> master)
//   o_irq       : registered masked interrupt           (slave -> master)
//   o_busy      : controller not idle                   (slave -> master)
// ---------------------------------------------------------------------------
interface input_debounce_ctrl_if;
  logic [31:0] i_sw_sync;
  logic        i_clr_en;
  logic [31:0] i_clr_mask;
  logic [31:0] i_irq_mask;
  logic [31:0] o_sw_stable;
  logic [31:0] o_pending;
  logic        o_change;
  logic        o_irq;
  logic        o_busy;

  modport master (
    output i_sw_sync, i_clr_en, i_clr_mask, i_irq_mask,
    input  o_sw_stable, o_pending, o_change, o_irq, o_busy
  );

  modport slave (
    input  i_sw_sync, i_clr_en, i_clr_mask, i_irq_mask,
    output o_sw_stable, o_pending, o_change, o_irq, o_busy
  );
endinterface

// File: rtl/input_debounce_ctrl.sv
// ---------------------------------------------------------------------------
// input_debounce_ctrl
//   Debounces the synchronized 32-bit switch word with one shared stability
//   counter, commits the settled value, records changed bits in a sticky
//   write-1-to-clear pending register and raises a masked level interrupt.
//
//   i_clk   : system clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : slave side of input_debounce_ctrl_if (switch word in, clear
//             strobe/mask, irq mask; stable word, pending, change pulse,
//             irq and busy out)
// ---------------------------------------------------------------------------
module input_debounce_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input_debounce_ctrl_if.slave         bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stable_q, stable_d;
  logic [31:0]      pending_q, pending_d;
  logic             change_q, change_d;
  logic             irq_q, irq_d;
  logic [31:0]      set_vec;
  logic [31:0]      clr_vec;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    set_vec  = '0;
    change_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_sw_sync != stable_q) begin
          cand_d  = bus.i_sw_sync;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // Returning to the committed value abandons the change entirely;
        // any other new value restarts the stability window.
        if (bus.i_sw_sync == stable_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (bus.i_sw_sync != cand_q) begin
          cand_d = bus.i_sw_sync;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COMMIT: begin
        // Input is ignored here; IDLE picks up any new difference next cycle.
        stable_d = cand_q;
        set_vec  = stable_q ^ cand_q;
        change_d = 1'b1;
        cnt_d    = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Set is OR-ed in after the clear, so a bit hit by both stays set.
    clr_vec   = bus.i_clr_en ? bus.i_clr_mask : 32'h0;
    pending_d = (pending_q & ~clr_vec) | set_vec;
    irq_d     = |(pending_d & bus.i_irq_mask);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      pending_q <= '0;
      change_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      pending_q <= pending_d;
      change_q  <= change_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.o_sw_stable = stable_q;
  assign bus.o_pending   = pending_q;
  assign bus.o_change    = change_q;
  assign bus.o_irq       = irq_q;
  assign bus.o_busy      = (state_q != IDLE);

endmodule
